// File: rtl/branch_target_predictor_pkg.sv
// Shared CPU types: 15-bit word-address program counter and its sequential successor.
package branch_target_predictor_pkg;

    localparam int unsigned PC_W = 15;

    typedef logic [PC_W-1:0] pc_t;

    // Fall-through PC; 0x7FFF wraps to 0x0000 through the natural 15-bit overflow.
    function automatic pc_t pc_next(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Lookup (fetch) and update (execute flush) signals of the branch-target predictor.
interface branch_target_predictor_if;
    import branch_target_predictor_pkg::*;

    pc_t  raddr0;
    pc_t  rdata0;
    logic wen;
    pc_t  waddr;
    pc_t  wdata;

    modport master (
        output raddr0,
        input  rdata0,
        output wen,
        output waddr,
        output wdata
    );

    modport slave (
        input  raddr0,
        output rdata0,
        input  wen,
        input  waddr,
        input  wdata
    );

endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged next-PC table with combinational lookup and write-through bypass.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    branch_target_predictor_if.slave    bus
);

    localparam int unsigned TAG_BITS = PC_W - INDEX_BITS;
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    pc_t                 r_target [ENTRIES];

    logic [INDEX_BITS-1:0] w_rindex;
    logic [INDEX_BITS-1:0] w_windex;
    logic [TAG_BITS-1:0]   w_rtag;
    logic [TAG_BITS-1:0]   w_wtag;
    logic                  w_hit;
    logic                  w_bypass;
    pc_t                   w_rdata;

    assign w_rindex = bus.raddr0[INDEX_BITS-1:0];
    assign w_rtag   = bus.raddr0[PC_W-1:INDEX_BITS];
    assign w_windex = bus.waddr[INDEX_BITS-1:0];
    assign w_wtag   = bus.waddr[PC_W-1:INDEX_BITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else if (bus.wen) begin
            r_valid[w_windex] <= 1'b1;
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (!reset && bus.wen) begin
            r_tag[w_windex]    <= w_wtag;
            r_target[w_windex] <= bus.wdata;
        end
    end

    assign w_hit    = r_valid[w_rindex] && (r_tag[w_rindex] == w_rtag);
    // Full-address match only; an index alias must not see the in-flight write.
    assign w_bypass = bus.wen && (bus.raddr0 == bus.waddr);

    always_comb begin
        w_rdata = pc_next(bus.raddr0);
        if (!reset) begin
            if (w_bypass) begin
                w_rdata = bus.wdata;
            end else if (w_hit) begin
                w_rdata = r_target[w_rindex];
            end
        end
    end

    assign bus.rdata0 = w_rdata;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed vector bench for branch_target_predictor (INDEX_BITS = 6).
module tb_branch_target_predictor;
    import branch_target_predictor_pkg::*;

    typedef struct {
        logic  reset;
        logic  wen;
        pc_t   waddr;
        pc_t   wdata;
        pc_t   raddr0;
        pc_t   exp;
        string name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    branch_target_predictor_if bus ();

    branch_target_predictor #(
        .INDEX_BITS (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic we, input pc_t wa, input pc_t wd,
                       input pc_t ra, input pc_t ex, input string nm);
        vec_t v;
        v.reset = rst; v.wen = we; v.waddr = wa; v.wdata = wd;
        v.raddr0 = ra; v.exp = ex; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input pc_t act, input pc_t ex);
        n_vec++;
        if (act !== ex) begin
            n_err++;
            $display("FAIL %s: rdata0=0x%04h expected 0x%04h", nm, act, ex);
        end
    endtask

    // Drive one cycle's inputs just after the edge, check mid-cycle, then take the edge.
    task automatic step(input logic rst, input logic we, input pc_t wa, input pc_t wd,
                        input pc_t ra, input pc_t ex, input string nm);
        reset      = rst;
        bus.wen    = we;
        bus.waddr  = wa;
        bus.wdata  = wd;
        bus.raddr0 = ra;
        #3;
        check(nm, bus.rdata0, ex);
        @(posedge clk);
        #1;
    endtask

    initial begin
        add(1, 1, 15'h0005, 15'h0123, 15'h0005, 15'h0006, "reset_no_bypass");
        add(0, 0, 15'h0000, 15'h0000, 15'h0000, 15'h0001, "cold_0000");
        add(0, 0, 15'h0000, 15'h0000, 15'h7FFF, 15'h0000, "cold_wrap");
        add(0, 1, 15'h0010, 15'h0040, 15'h0011, 15'h0012, "learn_other_addr");
        add(0, 0, 15'h0000, 15'h0000, 15'h0010, 15'h0040, "learn_hit");
        add(0, 0, 15'h0000, 15'h0000, 15'h0011, 15'h0012, "learn_neighbour_miss");
        add(0, 1, 15'h0020, 15'h0005, 15'h0020, 15'h0005, "bypass_same_cycle");
        add(0, 0, 15'h0000, 15'h0000, 15'h0020, 15'h0005, "bypass_after_edge");
        add(0, 1, 15'h0003, 15'h0100, 15'h0043, 15'h0044, "alias_write_first");
        add(0, 1, 15'h0043, 15'h0200, 15'h0003, 15'h0100, "alias_index_no_bypass");
        add(0, 0, 15'h0000, 15'h0000, 15'h0043, 15'h0200, "alias_new_hit");
        add(0, 0, 15'h0000, 15'h0000, 15'h0003, 15'h0004, "alias_old_evicted");
        add(0, 0, 15'h0000, 15'h0000, 15'h0010, 15'h0040, "pre_reset_hit");
        add(1, 1, 15'h0011, 15'h0077, 15'h0010, 15'h0011, "reset_reads_miss");
        add(0, 0, 15'h0000, 15'h0000, 15'h0010, 15'h0011, "reset_cleared");
        add(0, 0, 15'h0000, 15'h0000, 15'h0011, 15'h0012, "reset_write_dropped");
        add(0, 1, 15'h0030, 15'h0100, 15'h0000, 15'h0001, "nt_learn_taken");
        add(0, 0, 15'h0000, 15'h0000, 15'h0030, 15'h0100, "nt_taken_hit");
        add(0, 1, 15'h0030, 15'h0031, 15'h0030, 15'h0031, "nt_update_bypass");
        add(0, 0, 15'h0000, 15'h0000, 15'h0030, 15'h0031, "nt_update_hit");
        add(0, 1, 15'h7FFF, 15'h1234, 15'h003F, 15'h0040, "top_index_write");
        add(0, 0, 15'h0000, 15'h0000, 15'h7FFF, 15'h1234, "top_index_hit");
        add(0, 0, 15'h0000, 15'h0000, 15'h003F, 15'h0040, "top_index_alias_miss");

        #1;
        foreach (vecs[i]) begin
            step(vecs[i].reset, vecs[i].wen, vecs[i].waddr, vecs[i].wdata,
                 vecs[i].raddr0, vecs[i].exp, vecs[i].name);
        end

        // Held lookup with no writes keeps returning the stored target.
        step(0, 1, 15'h0005, 15'h0ABC, 15'h0000, 15'h0001, "hold_learn");
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 15'h0000, 15'h0000, 15'h0005, 15'h0ABC, "hold_reread");
        end

        // One-cycle reset pulse wipes entries written earlier in the run.
        step(1, 0, 15'h0000, 15'h0000, 15'h7FFF, 15'h0000, "pulse_during");
        step(0, 0, 15'h0000, 15'h0000, 15'h7FFF, 15'h0000, "pulse_top_cleared");
        step(0, 0, 15'h0000, 15'h0000, 15'h0005, 15'h0006, "pulse_hold_cleared");
        step(0, 0, 15'h0000, 15'h0000, 15'h0030, 15'h0031, "pulse_nt_cleared");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
